// File: rtl/fq_pkg.sv
// Shared types and constants for the fetch queue.
// Optional FQ_PERF_EN build adds perf counters on fetch_queue.
package fq_pkg;

    localparam int IW              = 16;
    localparam int AW              = 16;
    localparam int FQ_STALL_MARGIN = 4;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic          pred;
    } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Fetch-queue storage: two write ports at tail/tail+1, two async read ports
// at head/head+1. Contents are not reset.
module fq_ram
    import fq_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IXW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we0_i,
    input  logic [IXW-1:0] waddr0_i,
    input  fq_entry_t      wdata0_i,
    input  logic           we1_i,
    input  logic [IXW-1:0] waddr1_i,
    input  fq_entry_t      wdata1_i,
    input  logic [IXW-1:0] raddr0_i,
    output fq_entry_t      rdata0_o,
    input  logic [IXW-1:0] raddr1_i,
    output fq_entry_t      rdata1_o
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we0_i) mem[waddr0_i] <= wdata0_i;
        if (we1_i) mem[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem[raddr0_i];
    assign rdata1_o = mem[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// 2-wide fetch -> decode instruction queue with compaction, stall and flush.
// Define FQ_PERF_EN to add stall_cycles / flush_count outputs.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 16,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] I1,
    input  logic [IW-1:0] I2,
    input  logic          I1V,
    input  logic          I2V,
    input  logic          I1P,
    input  logic          I2P,
    input  logic [AW-1:0] I1PC,
    input  logic [AW-1:0] I2PC,
    input  logic          flush,
    input  logic [1:0]    deq_cnt,
    output logic          stall,
    output logic [IW-1:0] D1,
    output logic [IW-1:0] D2,
    output logic          D1V,
    output logic          D2V,
    output logic          D1P,
    output logic          D2P,
    output logic [AW-1:0] D1PC,
    output logic [AW-1:0] D2PC
`ifdef FQ_PERF_EN
    ,
    output logic [15:0]   stall_cycles,
    output logic [15:0]   flush_count
`endif
);

    import fq_pkg::*;

    localparam int IXW = $clog2(DEPTH);
    localparam int PW  = IXW + 1;

    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]  count, space, deq_eff, enq_req, enq_acc;
    logic           slot2_ok, we0, we1;
    logic [IXW-1:0] tail_ix, head_ix;
    fq_entry_t      e1, e2, wdata0, rd0, rd1;

    assign count    = tail_q - head_q;
    assign space    = PW'(DEPTH) - count;
    // A predicted-taken I1 makes I2 wrong-path.
    assign slot2_ok = I2V && !(I1V && I1P);
    assign enq_req  = PW'(I1V) + PW'(slot2_ok);
    assign enq_acc  = (enq_req > space) ? space : enq_req;
    assign deq_eff  = (PW'(deq_cnt) > count) ? count : PW'(deq_cnt);

    assign e1     = '{instr: I1, pc: I1PC, pred: I1P};
    assign e2     = '{instr: I2, pc: I2PC, pred: I2P};
    assign wdata0 = I1V ? e1 : e2;
    assign we0    = !flush && (enq_acc != '0);
    assign we1    = !flush && (enq_acc == PW'(2));

    assign tail_ix = tail_q[IXW-1:0];
    assign head_ix = head_q[IXW-1:0];

    always_comb begin
        head_d = head_q + deq_eff;
        tail_d = tail_q + enq_acc;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    fq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (tail_ix),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (tail_ix + IXW'(1)),
        .wdata1_i (e2),
        .raddr0_i (head_ix),
        .rdata0_o (rd0),
        .raddr1_i (head_ix + IXW'(1)),
        .rdata1_o (rd1)
    );

    assign D1V   = (count != '0);
    assign D2V   = (count >= PW'(2));
    assign D1    = D1V ? rd0.instr : '0;
    assign D1PC  = D1V ? rd0.pc    : '0;
    assign D1P   = D1V && rd0.pred;
    assign D2    = D2V ? rd1.instr : '0;
    assign D2PC  = D2V ? rd1.pc    : '0;
    assign D2P   = D2V && rd1.pred;
    assign stall = space < PW'(FQ_STALL_MARGIN);

`ifdef FQ_PERF_EN
    logic [15:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 16'd1;
            if (flush && flush_count_q != '1)  flush_count_q  <= flush_count_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        flush || (enq_req <= space))
        else $error("fetch_queue: enqueue beyond capacity");

endmodule
